load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 100, meaning number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 req_valid  input  1  pipeline presents an access.
REQ-006 req_ready  output  1  unit can accept an access; high only in IDLE.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle pulse: access complete.
REQ-012 resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-013 resp_err  output  1  valid with resp_valid; misaligned, out-of-range or illegal funct3.
REQ-014 mem_we  output  1  write enable to data memory.
REQ-015 mem_addr  output  32  word index to data memory (= req_addr[31:2] latched).
REQ-016 mem_wd  output  32  write data to data memory.
REQ-017 mem_rd  input  32  combinational read data from data memory at mem_addr.

Function
REQ-018 Handshake: an access SHALL be accepted on a rising edge where req_valid && req_ready; opcode, address and data are latched then; inputs are ignored at all other times.
REQ-019 FSM states SHALL be IDLE, LOAD, RMW_RD, STORE, RESP; state changes only on rising clk.
REQ-020 From IDLE on acceptance: error -> RESP with err; load -> LOAD; SW -> STORE; SB/SH -> RMW_RD; otherwise stay IDLE.
REQ-021 Error SHALL be: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; word index >= DEPTH; funct3 011/110/111; store with funct3 100/101.
REQ-022 LOAD: mem_addr = latched index, mem_we=0; mem_rd captured, byte/halfword selected by addr[1:0] (little-endian), sign- or zero-extended per funct3; next state RESP.
REQ-023 RMW_RD: mem_we=0; mem_rd captured and merged with store byte/halfword at addr[1:0] lane, other lanes preserved; next state STORE.
REQ-024 STORE: mem_we=1 for exactly one cycle, mem_wd = full word (SW) or merged word (SB/SH); next state RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then IDLE.
REQ-026 mem_we SHALL be 0 in every state except STORE; an errored access SHALL never assert mem_we.
REQ-027 Latency from accepting edge N: resp_valid high after edge N+1 for errors, N+2 for loads and SW, N+3 for SB/SH.
REQ-028 Back-to-back: req_ready SHALL return high in the cycle after RESP; no overlap of accesses; a request held during busy states is accepted only once IDLE is reached.
REQ-029 mem_addr SHALL hold the latched index from acceptance until IDLE; in IDLE mem_addr=0, mem_wd=0.

Reset
REQ-030 On a rising edge with rst=0: state=IDLE, req_ready=1 after edge, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wd=0, all latches cleared.
REQ-031 Reset mid-access (any non-IDLE state) SHALL abort it: no resp_valid pulse, and mem_we deasserted from the reset edge onward.

Verification
REQ-032 LB addr 0x0000_0007, memory word 1 = 0x80AB_CDEF -> resp_valid at N+2, resp_rdata=0xFFFF_FF80, resp_err=0; LBU same -> 0x0000_0080.
REQ-033 SB addr 0x0000_0005 wdata 0x1234_5677, word 1 = 0xAABB_CCDD -> mem_we one cycle at N+2..N+3 with mem_wd=0xAABB_77DD, mem_addr=1, resp_valid at N+3.
REQ-034 SW addr 0x0000_0002 -> resp_valid at N+1 with resp_err=1, mem_we never high; LW addr 0x0000_0190 (index 100) -> resp_err=1.
REQ-035 LH addr 0x0000_000A, word 2 = 0x8001_7FFF -> resp_rdata=0xFFFF_8001; LHU -> 0x0000_8001.
REQ-036 rst=0 asserted while in STORE of SH -> no resp_valid, mem_we=0 after edge, req_ready=1 after reset released.
REQ-037 req_valid held high for SW then LW to same address 0x0000_0010 wdata 0xDEAD_BEEF -> two separate accepts, LW returns 0xDEAD_BEEF, req_ready low during busy cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the pipeline
// and a word-organised data memory. Sub-word stores are performed as a
// read-modify-write so the memory only ever needs full-word writes.
module load_store_unit #(
  parameter int DEPTH = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } state_t;

  localparam logic [31:0] DepthWords = 32'(DEPTH);

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wData;
  logic        r_err;
  logic [31:0] r_rData;

  logic [31:0] w_reqIdx;
  logic        w_badFunct3;
  logic        w_misaligned;
  logic        w_outOfRange;
  logic        w_reqErr;
  logic [4:0]  w_shamt;
  logic [31:0] w_loadShifted;
  logic [31:0] w_loadData;
  logic [31:0] w_laneMask;
  logic [31:0] w_laneData;
  logic [31:0] w_merged;

  // Classify the incoming request: illegal size code, misalignment or an index past the memory.
  always_comb begin
    w_reqIdx     = {2'b00, req_addr[31:2]};
    w_outOfRange = (w_reqIdx >= DepthWords);
    if (req_we) begin
      w_badFunct3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      w_badFunct3 = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1]);
    end
    w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_reqErr     = w_badFunct3 || w_misaligned || w_outOfRange;
  end

  // Lane selection for loads (extract + extend) and for sub-word store merging.
  always_comb begin
    w_shamt       = {r_addr[1:0], 3'b000};
    w_loadShifted = mem_rd >> w_shamt;
    w_loadData    = mem_rd;
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_loadShifted[7]}}, w_loadShifted[7:0]};
      3'b001:  w_loadData = {{16{w_loadShifted[15]}}, w_loadShifted[15:0]};
      3'b100:  w_loadData = {24'h000000, w_loadShifted[7:0]};
      3'b101:  w_loadData = {16'h0000, w_loadShifted[15:0]};
      default: w_loadData = mem_rd;
    endcase
    w_laneMask = ((r_funct3[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    w_laneData = r_wData << w_shamt;
    w_merged   = (mem_rd & ~w_laneMask) | (w_laneData & w_laneMask);
  end

  // Next-state selection; errored requests skip straight to the response.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_reqErr) begin
            w_nextState = RESP;
          end else if (!req_we) begin
            w_nextState = LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            w_nextState = STORE;
          end else begin
            w_nextState = RMW_RD;
          end
        end
      end
      LOAD:    w_nextState = RESP;
      RMW_RD:  w_nextState = STORE;
      STORE:   w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus the request latches, load result capture and store merge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wData  <= 32'h0;
      r_err    <= 1'b0;
      r_rData  <= 32'h0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wData  <= req_wdata;
            r_err    <= w_reqErr;
            r_rData  <= 32'h0;
          end
        end
        LOAD:    r_rData <= w_loadData;
        RMW_RD:  r_wData <= w_merged;
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state; memory address is held while busy and zero when idle.
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    resp_err   = (r_state == RESP) && r_err;
    resp_rdata = (r_state == RESP) ? r_rData : 32'h0;
    mem_we     = (r_state == STORE);
    mem_addr   = (r_state == IDLE) ? 32'h0 : {2'b00, r_addr[31:2]};
    mem_wd     = (r_state == STORE) ? r_wData : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives directed and random accesses into load_store_unit
// backed by a simple word memory, and compares every response against a
// behavioural model of the memory contents and access rules.
module tb_load_store_unit;

  localparam int Depth = 100;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dutMem [Depth];
  logic [31:0] refMem [Depth];
  logic        initMem;

  int total = 0;
  int bad   = 0;

  logic [31:0] obsRdata;
  logic        obsErr;

  load_store_unit #(.DEPTH(Depth)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational read port of the attached memory.
  assign mem_rd = (mem_addr < 32'(Depth)) ? dutMem[mem_addr[6:0]] : 32'h0;

  // Attached memory: bulk load from the model image, otherwise accept DUT writes.
  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < Depth; i++) dutMem[i] <= refMem[i];
    end else if (rst && mem_we && (mem_addr < 32'(Depth))) begin
      dutMem[mem_addr[6:0]] <= mem_wd;
    end
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Copy the model memory image into the attached memory.
  task automatic syncMemory();
    @(negedge clk);
    initMem = 1'b1;
    @(negedge clk);
    initMem = 1'b0;
  endtask

  // Issue one access, observe it to completion and check it against the model.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    int          sz;
    int          sh;
    bit          isErr;
    int          expLat;
    logic [31:0] expRdata;
    logic [31:0] word;
    logic [31:0] part;
    logic [31:0] newWord;
    int          lat;
    int          weCount;
    logic [31:0] weAddr;
    logic [31:0] weData;
    int          readyBad;
    int          addrBad;
    int          guard;

    // behavioural model of the access
    idx      = int'(addr >> 2);
    sh       = int'(addr % 4) * 8;
    sz       = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    if (we) isErr = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    isErr = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!isErr && ((addr % sz) != 0)) isErr = 1'b1;
    if (idx >= Depth) isErr = 1'b1;
    expRdata = 32'h0;
    newWord  = 32'h0;
    if (isErr) expLat = 1;
    else if (!we || f3 == 3'd2) expLat = 2;
    else expLat = 3;
    if (!isErr) begin
      word = refMem[idx];
      if (!we) begin
        if (sz == 4) begin
          expRdata = word;
        end else begin
          part = (word >> sh) % ((sz == 1) ? 32'd256 : 32'd65536);
          expRdata = part;
          if (f3 == 3'd0 && part >= 32'd128) expRdata = part - 32'd256;
          if (f3 == 3'd1 && part >= 32'd32768) expRdata = part - 32'd65536;
        end
      end else begin
        if (sz == 4) begin
          newWord = wdata;
        end else begin
          part    = (word >> sh) % ((sz == 1) ? 32'd256 : 32'd65536);
          newWord = word - (part << sh) + ((wdata % ((sz == 1) ? 32'd256 : 32'd65536)) << sh);
        end
        refMem[idx] = newWord;
      end
    end

    // drive the request once the unit is ready
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    lat      = 0;
    weCount  = 0;
    weAddr   = 32'h0;
    weData   = 32'h0;
    readyBad = 0;
    addrBad  = 0;
    obsRdata = 32'h0;
    obsErr   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (mem_we) begin
        weCount++;
        weAddr = mem_addr;
        weData = mem_wd;
      end
      if (mem_addr !== (addr >> 2)) addrBad++;
      if (resp_valid) begin
        lat      = k;
        obsRdata = resp_rdata;
        obsErr   = resp_err;
        break;
      end
      if (req_ready) readyBad++;
    end

    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("respErr", {31'h0, obsErr}, {31'h0, isErr});
    checkOutput("respRdata", obsRdata, expRdata);
    checkOutput("memWeCount", 32'(weCount), (we && !isErr) ? 32'd1 : 32'd0);
    if (we && !isErr) begin
      checkOutput("memWeAddr", weAddr, 32'(idx));
      checkOutput("memWd", weData, newWord);
    end
    checkOutput("readyLowWhileBusy", 32'(readyBad), 32'd0);
    checkOutput("memAddrHeld", 32'(addrBad), 32'd0);

    @(posedge clk);
    #1;
    checkOutput("idleAfterResp", {28'h0, req_ready, resp_valid, mem_addr == 32'h0, mem_wd == 32'h0}, 32'h0000_000B);
  endtask

  int          accepts;
  int          lwAcceptEdge;
  int          resps;
  int          readyLow;
  logic [31:0] lastData;
  bit          rdyBefore;
  bit          sawResp;
  int          diffs;

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    initMem    = 1'b0;
    for (int i = 0; i < Depth; i++) refMem[i] = $urandom;
    refMem[1] = 32'h80AB_CDEF;
    refMem[2] = 32'h8001_7FFF;
    syncMemory();
    @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rstReady", {31'h0, req_ready}, 32'h1);
    checkOutput("rstRespValid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rstRespErr", {31'h0, resp_err}, 32'h0);
    checkOutput("rstRdata", resp_rdata, 32'h0);
    checkOutput("rstMemWe", {31'h0, mem_we}, 32'h0);
    checkOutput("rstMemAddr", mem_addr, 32'h0);
    checkOutput("rstMemWd", mem_wd, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 3'b000, 32'h0000_0007, 32'h0);
    checkOutput("lbValue", obsRdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b100, 32'h0000_0007, 32'h0);
    checkOutput("lbuValue", obsRdata, 32'h0000_0080);
    applyStimulus(1'b0, 3'b001, 32'h0000_000A, 32'h0);
    checkOutput("lhValue", obsRdata, 32'hFFFF_8001);
    applyStimulus(1'b0, 3'b101, 32'h0000_000A, 32'h0);
    checkOutput("lhuValue", obsRdata, 32'h0000_8001);
    refMem[1] = 32'hAABB_CCDD;
    syncMemory();
    applyStimulus(1'b1, 3'b000, 32'h0000_0005, 32'h1234_5677);
    checkOutput("sbMerged", refMem[1], 32'hAABB_77DD);
    applyStimulus(1'b1, 3'b010, 32'h0000_0002, 32'h5555_5555);
    checkOutput("swMisalignErr", {31'h0, obsErr}, 32'h1);
    applyStimulus(1'b0, 3'b010, 32'h0000_0190, 32'h0);
    checkOutput("lwOutOfRangeErr", {31'h0, obsErr}, 32'h1);
    applyStimulus(1'b0, 3'b010, 32'h0000_018C, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h0000_000E, 32'hCAFE_BEEF);

    $display("[TB] reset during store");
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h0000_0006;
    req_wdata  = 32'h0000_1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abortInStore", {31'h0, mem_we}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abortMemWe", {31'h0, mem_we}, 32'h0);
    checkOutput("abortRespValid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    sawResp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_we) sawResp = 1'b1;
    end
    checkOutput("abortNoResp", {31'h0, sawResp}, 32'h0);
    checkOutput("abortReady", {31'h0, req_ready}, 32'h1);

    $display("[TB] back-to-back held request");
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0010;
    req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    refMem[4]  = 32'hDEAD_BEEF;
    req_we     = 1'b0;
    req_wdata  = 32'h0;
    accepts      = 1;
    lwAcceptEdge = 0;
    resps        = 0;
    readyLow     = 0;
    lastData     = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      rdyBefore = req_ready;
      if (!rdyBefore) readyLow++;
      @(posedge clk);
      #1;
      if (rdyBefore && req_valid) begin
        accepts++;
        lwAcceptEdge = k;
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        resps++;
        lastData = resp_rdata;
      end
    end
    checkOutput("b2bAccepts", 32'(accepts), 32'd2);
    checkOutput("b2bSecondAcceptEdge", 32'(lwAcceptEdge), 32'd3);
    checkOutput("b2bResponses", 32'(resps), 32'd2);
    checkOutput("b2bLoadData", lastData, 32'hDEAD_BEEF);
    checkOutput("b2bReadyLowCycles", 32'(readyLow), 32'd4);

    $display("[TB] random accesses");
    for (int n = 0; n < 80; n++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 32'h1AF);
      if ($urandom_range(0, 1) == 0) ra = ra & 32'hFFFF_FFFC;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
    end

    diffs = 0;
    for (int i = 0; i < Depth; i++) if (dutMem[i] !== refMem[i]) diffs++;
    checkOutput("memImage", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
